// File: rtl/adder_sequencer.sv
// adder_sequencer: operator FSM that loads A/B from debounced keys and registers the external adder's result.
// Define ADDER_SEQ_ACCUM_EN to make a load press in S_DONE add sw_data onto the previous result.
module adder_sequencer #(
    parameter int N = 8,
    parameter int ADD_LAT = 0,
    parameter int DB_CYCLES = 500000
) (
    input  logic         CLOCK_50,
    input  logic         Resetn,
    input  logic         load_key_n,
    input  logic         clear_key_n,
    input  logic [N-1:0] sw_data,
    input  logic         sw_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         done,
    output logic [1:0]   state
);
    localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int LW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    logic [1:0] keys_n, press;
    logic [LW-1:0] wcnt;
    assign keys_n = {clear_key_n, load_key_n};
    // press[0] = load, press[1] = clear; each is one cycle after the accepted level falls
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic sync1, sync2, level, level_d;
        logic [DW-1:0] cnt;
        always_ff @(posedge CLOCK_50 or negedge Resetn)
            if (!Resetn) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                level <= 1'b1;
                level_d <= 1'b1;
                cnt <= '0;
            end else begin
                sync1 <= keys_n[k];
                sync2 <= sync1;
                level_d <= level;
                if (sync2 == level)
                    cnt <= '0;
                else if (cnt == DW'(DB_CYCLES - 1)) begin
                    cnt <= '0;
                    level <= sync2;
                end else
                    cnt <= cnt + 1'b1;
            end
        assign press[k] = level_d & ~level;
    end
    always_ff @(posedge CLOCK_50 or negedge Resetn)
        if (!Resetn) begin
            state <= S_A;
            add_a <= '0;
            add_b <= '0;
            add_cin <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
            overflow <= 1'b0;
            done <= 1'b0;
            wcnt <= '0;
        end else if (press[1]) begin
            state <= S_A;
            add_a <= '0;
            add_b <= '0;
            add_cin <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                S_A: if (press[0]) begin
                    add_a <= sw_data;
                    state <= S_B;
                end
                S_B: if (press[0]) begin
                    add_b <= sw_data;
                    add_cin <= sw_cin;
                    wcnt <= LW'(ADD_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: if (wcnt == '0) begin
                    result <= add_sum;
                    carry_out <= add_cout;
                    overflow <= (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);
                    done <= 1'b1;
                    state <= S_DONE;
                end else
                    wcnt <= wcnt - 1'b1;
                default: if (press[0]) begin
`ifdef ADDER_SEQ_ACCUM_EN
                    add_a <= result;
                    add_b <= sw_data;
                    add_cin <= sw_cin;
                    wcnt <= LW'(ADD_LAT);
                    state <= S_WAIT;
`else
                    add_a <= sw_data;
                    state <= S_B;
`endif
                    done <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_adder_sequencer.sv
// tb_adder_sequencer: vector table, hand-written key sequences and random adds against an arithmetic model.
module tb_adder_sequencer;
    localparam int N = 8;
    logic clk = 1'b0, rst_n = 1'b0, load_n = 1'b1, clear_n = 1'b1, sw_cin = 1'b0;
    logic [N-1:0] sw_data = '0;
    logic [N-1:0] add_a, add_b, add_sum, result;
    logic add_cin, add_cout, carry_out, overflow, done;
    logic [1:0] state;
    logic [N:0] p1 = '0, p2 = '0;
    int checks = 0, errors = 0;
    typedef struct {
        logic [7:0] a, b;
        logic cin;
        logic [7:0] sum;
        logic cout, ovf;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    // behavioural adder with two cycles of latency
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + add_b + add_cin;
        p2 <= p1;
    end
    assign add_sum = p2[N-1:0];
    assign add_cout = p2[N];

    adder_sequencer #(.N(N), .ADD_LAT(2), .DB_CYCLES(4)) dut (
        .CLOCK_50(clk), .Resetn(rst_n), .load_key_n(load_n), .clear_key_n(clear_n),
        .sw_data(sw_data), .sw_cin(sw_cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .result(result), .carry_out(carry_out),
        .overflow(overflow), .done(done), .state(state)
    );

    function automatic void model(input logic [7:0] a, b, input logic c,
                                  output logic [7:0] s, output logic co, ov);
        int u, sg;
        u = int'(a) + int'(b) + int'(c);
        sg = int'($signed(a)) + int'($signed(b)) + int'(c);
        s = 8'(u);
        co = u > 255;
        ov = sg > 127 || sg < -128;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic is_clear, input int hold);
        if (is_clear) clear_n = 1'b0;
        else load_n = 1'b0;
        tick(hold);
        load_n = 1'b1;
        clear_n = 1'b1;
        tick(12);
    endtask

    task automatic run_add(input logic [7:0] a, b, input logic c);
        press(1'b1, 10);
        sw_data = a;
        press(1'b0, 10);
        sw_data = b;
        sw_cin = c;
        press(1'b0, 10);
    endtask

    initial begin
        logic [7:0] ea, eb, es;
        logic ec, ecout, eovf, seen1, seen2;
        int t2, td;
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        // reset with both keys held
        load_n = 1'b0;
        clear_n = 1'b0;
        sw_data = 8'hA5;
        sw_cin = 1'b1;
        tick(5);
        chk("rst_state", state, 0);
        chk("rst_outs", {add_a, add_b, add_cin, result, carry_out, overflow, done}, 0);
        load_n = 1'b1;
        clear_n = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(12);
        chk("rst_idle_state", state, 0);
        chk("rst_idle_done", done, 0);
        // exact latency from B press to done
        press(1'b1, 10);
        sw_data = 8'h05;
        press(1'b0, 10);
        chk("a_loaded_state", state, 1);
        chk("a_loaded", add_a, 8'h05);
        sw_data = 8'h03;
        sw_cin = 1'b0;
        load_n = 1'b0;
        t2 = -1;
        td = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (state == 2'd2 && t2 < 0) t2 = i;
            if (done && td < 0) td = i;
        end
        load_n = 1'b1;
        tick(12);
        chk("lat_done_seen", td >= 0 && t2 >= 0, 1);
        chk("lat_cycles", td - t2, 3);
        chk("basic_result", result, 8'h08);
        chk("basic_flags", {carry_out, overflow, done, state}, {1'b0, 1'b0, 1'b1, 2'd3});
        // vector table
        for (int i = 0; i < 7; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("vec%0d_sum", i), result, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), carry_out, vecs[i].cout);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("vec%0d_done", i), {done, state}, {1'b1, 2'd3});
        end
        // debounce: short and gapped glitches are rejected
        press(1'b1, 10);
        load_n = 1'b0;
        tick(3);
        load_n = 1'b1;
        tick(12);
        chk("db_short", state, 0);
        load_n = 1'b0;
        tick(3);
        load_n = 1'b1;
        tick(1);
        load_n = 1'b0;
        tick(3);
        load_n = 1'b1;
        tick(12);
        chk("db_gap", state, 0);
        // long hold gives exactly one press
        sw_data = 8'h20;
        load_n = 1'b0;
        t2 = 0;
        ec = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (state != 2'd0 && !ec) begin
                t2++;
                ec = 1'b1;
            end
            if (state != 2'd1 && ec) t2++;
        end
        load_n = 1'b1;
        tick(12);
        chk("db_hold_transitions", t2, 1);
        chk("db_hold_state", state, 1);
        // key activity during S_WAIT and operand switches changing must not disturb the add
        sw_data = 8'h10;
        sw_cin = 1'b1;
        load_n = 1'b0;
        tick(8);
        sw_data = 8'hAA;
        sw_cin = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 5) load_n = 1'b1;
            if (i == 6) load_n = 1'b0;
            if (i == 7) load_n = 1'b1;
            if (state == 2'd1) seen1 = 1'b1;
        end
        chk("wait_no_sb", seen1, 0);
        chk("wait_state", state, 3);
        chk("wait_result", result, 8'h31);
        // clear and load together in S_B
        press(1'b1, 10);
        sw_data = 8'h33;
        press(1'b0, 10);
        sw_data = 8'h77;
        load_n = 1'b0;
        clear_n = 1'b0;
        tick(10);
        load_n = 1'b1;
        clear_n = 1'b1;
        tick(12);
        chk("clr_state", state, 0);
        chk("clr_add_a", add_a, 0);
        chk("clr_done", done, 0);
        // reset mid-operation
        sw_data = 8'h09;
        press(1'b0, 10);
        load_n = 1'b0;
        td = -1;
        for (int i = 0; i < 20 && td < 0; i++) begin
            tick(1);
            if (state == 2'd2) td = i;
        end
        chk("midrst_reach_wait", td >= 0, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {add_a, add_b, add_cin, result, carry_out, overflow, done, state}, 0);
        load_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(12);
        chk("midrst_idle", state, 0);
`ifdef ADDER_SEQ_ACCUM_EN
        run_add(8'h05, 8'h03, 1'b0);
        chk("acc_first", result, 8'h08);
        sw_data = 8'h04;
        sw_cin = 1'b0;
        load_n = 1'b0;
        seen1 = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state == 2'd1) seen1 = 1'b1;
            if (state == 2'd2) seen2 = 1'b1;
        end
        load_n = 1'b1;
        tick(12);
        chk("acc_result", result, 8'h0C);
        chk("acc_no_sb", seen1, 0);
        chk("acc_wait", seen2, 1);
        chk("acc_state", {done, state}, {1'b1, 2'd3});
`else
        run_add(8'h40, 8'h02, 1'b0);
        sw_data = 8'h11;
        press(1'b0, 10);
        chk("redo_state", state, 1);
        chk("redo_done", done, 0);
        chk("redo_add_a", add_a, 8'h11);
        chk("redo_result_held", result, 8'h42);
`endif
        // random adds with occasional rejected glitches before the B press
        for (int i = 0; i < 20; i++) begin
            ea = 8'($urandom);
            eb = 8'($urandom);
            ec = 1'($urandom);
            press(1'b1, 10);
            sw_data = ea;
            press(1'b0, $urandom_range(6, 20));
            if ($urandom_range(1) == 1) begin
                load_n = 1'b0;
                tick($urandom_range(1, 3));
                load_n = 1'b1;
                tick(4);
            end
            sw_data = eb;
            sw_cin = ec;
            press(1'b0, $urandom_range(6, 20));
            model(ea, eb, ec, es, ecout, eovf);
            chk($sformatf("rnd%0d_sum", i), result, es);
            chk($sformatf("rnd%0d_flags", i), {carry_out, overflow}, {ecout, eovf});
            chk($sformatf("rnd%0d_done", i), {done, state}, {1'b1, 2'd3});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Operator-facing controller that sequences an external N-bit adder datapath on the DE-series board.
- Captures operand A, then operand B, from the SW switches on debounced pushbutton presses, and drives them onto the adder inputs.
- Waits out the adder latency, then registers sum, carry and signed overflow for display on HEX/LEDR.
- Sits between the board I/O (SW, KEY) and the adder instance inside top.

Parameters:
- N, 8, operand/sum width in bits (N >= 2).
- ADD_LAT, 0, adder latency in clock cycles from operand change to valid sum (0 = combinational adder).
- DB_CYCLES, 500000, consecutive stable cycles required to accept a key level (DB_CYCLES >= 1; benches use 4).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous active-low reset.
- load_key_n  in  1  active-low pushbutton, asynchronous to CLOCK_50: load operand / advance.
- clear_key_n  in  1  active-low pushbutton, asynchronous: abort and clear.
- sw_data  in  N  operand value from the switches.
- sw_cin  in  1  carry-in switch, sampled with operand B.
- add_a  out  N  operand A to the adder.
- add_b  out  N  operand B to the adder.
- add_cin  out  1  carry-in to the adder.
- add_sum  in  N  sum from the adder.
- add_cout  in  1  carry-out from the adder.
- result  out  N  registered sum.
- carry_out  out  1  registered carry-out.
- overflow  out  1  registered two's-complement overflow.
- done  out  1  result valid.
- state  out  2  current state code, drives LEDR.

Behaviour:
- Reset: Resetn is asynchronous and active-low, with one clock, CLOCK_50. While Resetn=0 every output is 0 and the FSM is in S_A. Reset asserted mid-operation aborts immediately; no partial result survives.
- Key conditioning, per key:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles. Any mismatch gap restarts the count.
  - A press is a one-cycle pulse on an accepted 1->0 transition. Holding a key produces exactly one press. Release produces nothing.
  - Accepted levels reset to 1 (released).
- State codes: S_A=0, S_B=1, S_WAIT=2, S_DONE=3.
- S_A: on load press, add_a <= sw_data; go to S_B.
- S_B: on load press, add_b <= sw_data and add_cin <= sw_cin; wait counter <= ADD_LAT; go to S_WAIT.
- S_WAIT:
  - If counter == 0: result <= add_sum, carry_out <= add_cout, overflow <= (add_a[N-1]==add_b[N-1]) && (add_sum[N-1]!=add_a[N-1]), done <= 1; go to S_DONE.
  - Otherwise decrement the counter.
  - Total latency from the B press pulse to done=1 is ADD_LAT+2 cycles.
  - Load presses in S_WAIT are discarded, not queued.
- S_DONE:
  - result, flags and done hold.
  - On load press: add_a <= sw_data, done <= 0; go to S_B. result holds its old value until the next capture.
- Clear press, any state: add_a, add_b, add_cin, result, carry_out, overflow and done all go to 0; go to S_A. Clear wins over a load press in the same cycle.
- Arithmetic is modulo 2^N. carry_out is the unsigned carry. add_a and add_b are stable for the whole of S_WAIT.

Optional Feature:
- Macro: ADDER_SEQ_ACCUM_EN.
- Defined: a load press in S_DONE sets add_a <= result, add_b <= sw_data and add_cin <= sw_cin, reloads the counter and goes directly to S_WAIT, giving a running accumulator. done drops to 0 on that press. S_A and S_B behave as above.
- Undefined: S_DONE behaves as in Behaviour.

Test Plan:
- Bench setup: N=8, ADD_LAT=2, DB_CYCLES=4, behavioural adder with 2-cycle delay.
- Reset: Resetn=0 with keys pressed -> all outputs 0, state=0. Release reset -> state stays 0 until a press.
- Basic add: sw=0x05, press; sw=0x03, sw_cin=0, press -> result=0x08, carry_out=0, overflow=0, done=1, state=3 exactly 4 cycles after the B press pulse.
- Boundaries:
  - 0x7F+0x01 -> result=0x80, overflow=1, carry_out=0.
  - 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0.
  - 0xFF+0x00 with cin=1 -> result=0x00, carry_out=1.
- Debounce:
  - load_key_n low for 3 cycles then high -> no state change.
  - Low for 100 cycles -> exactly one transition.
  - Press during S_WAIT -> ignored; state returns to 3, not 1.
- Clear: in S_B, press clear and load in the same cycle -> state=0, add_a=0, done=0.
- ADDER_SEQ_ACCUM_EN defined: 5+3 -> 0x08; sw=0x04, press -> result=0x0C, state passes 3->2->3 without visiting 1.
